uart_modo_rx: RTL and testbench
===============================

# uart_modo_rx

Serial front end that receives LCD operating-mode commands over a UART line and drives the 8-bit `modooperacao` input of the LCD1602 controller. It sits directly upstream of LCD1602 and replaces the processor PIO as the mode source. A 3-byte packet, SYNC + MODE + CHECK, is validated before the output register changes. Malformed or corrupted traffic never reaches the LCD.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 9600: line rate, 8N1.
- `SYNC_BYTE`, 8'hA5: packet header.
- `RESET_MODE`, 8'h00: `modooperacao` value after reset.
- `TIMEOUT_BITS`, 20: inter-byte timeout, in bit times.

Ports:
- `clk` in 1: single system clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rxd` in 1: asynchronous UART line, idles high.
- `modooperacao` out 8: registered mode byte for LCD1602.
- `modo_valid` out 1: one-cycle pulse when `modooperacao` is updated.
- `frame_err` out 1: one-cycle pulse on a bad stop bit (or parity error, see Configuration).
- `pkt_err` out 1: one-cycle pulse on a check mismatch or timeout.
- `busy` out 1: high while the packet FSM is not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Oversample tick: divider `DIV = CLK_HZ/(BAUD*16)`, integer, truncated. For 50 MHz / 9600, DIV = 325. The divider free-runs only while a byte is being received; otherwise it is held at 0.
- Byte receiver states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE → R_START on a synchronized falling edge.
  - R_START: at tick 8, if the line is low, go to R_DATA. If the line is high, it was a glitch; return to R_IDLE with no error.
  - R_DATA: sample every 16 ticks, LSB first, 8 bits.
  - R_STOP: sample after 16 ticks. If the line is high, raise the byte strobe. If the line is low, pulse `frame_err`, discard the byte, and wait for the line to go high before returning to R_IDLE.
- Packet FSM states: IDLE, GOT_SYNC, GOT_MODE.
  - IDLE: a byte equal to SYNC_BYTE moves to GOT_SYNC. Any other byte is ignored silently.
  - GOT_SYNC: any byte, including SYNC_BYTE, is latched as the mode candidate; move to GOT_MODE.
  - GOT_MODE: if the byte equals the bitwise inverse of the candidate, load `modooperacao`, pulse `modo_valid`, and go to IDLE. Otherwise pulse `pkt_err` and go to IDLE. No resync on this byte.
- Timeout: a counter of tick/16 units restarts on each byte strobe while in GOT_SYNC or GOT_MODE. When it reaches TIMEOUT_BITS, pulse `pkt_err` and go to IDLE.
- A `frame_err` in GOT_SYNC or GOT_MODE also sends the FSM to IDLE. `pkt_err` is not pulsed in that case.
- `modooperacao` holds its value indefinitely between valid packets.

## Timing
- Reset values: `modooperacao` = RESET_MODE; `modo_valid`, `frame_err`, `pkt_err`, `busy` = 0; both FSMs in idle; divider and timeout counters = 0.
- Byte strobe is asserted 1 cycle after the stop-bit sample.
- `modooperacao` and `modo_valid` change 1 cycle after the CHECK strobe. LCD1602 sees the new value on that same edge.
- Synchronizer latency is 2 cycles from an `rxd` edge.
- If a timeout and a byte strobe fall in the same cycle, the byte wins and the timeout counter clears.
- Reset asserted mid-byte or mid-packet aborts everything on the next edge. The output returns to RESET_MODE, and no error pulses are generated.
- Back-to-back packets with zero idle time between stop and the next start bit are accepted.

## Configuration
- `UART_PARITY_EN` defined: frame is 8E1. A parity bit is sampled 16 ticks after bit 7. An even-parity failure pulses `frame_err` at the stop-bit sample and discards the byte.
- `UART_PARITY_EN` undefined: frame is 8N1, and there is no parity logic.

## Structure
- Shared package `uart_modo_pkg`:
  - packet FSM state enum;
  - receiver state enum;
  - `OVS = 16`;
  - `SAMPLE_MID = 8`.
- Sub-module `uart_rx_core`: synchronizer, divider, byte receiver. It outputs the byte, the strobe, and `frame_err`.
- The top level contains the packet FSM, the timeout counter, and the output register.

## Test plan
- Send A5 3C C3 at 9600 baud → `modooperacao` = 8'h3C, with a single `modo_valid` pulse 1 cycle after the C3 stop sample.
- Send A5 3C C4 → `pkt_err` pulses once, `modooperacao` keeps its prior value, and `busy` returns to 0.
- Send A5, then idle for 25 bit times → `pkt_err` pulses at bit time 20 and the FSM is in IDLE; a following A5 12 ED yields 8'h12.
- Send A5 with the stop bit forced low → `frame_err` pulses, there is no packet progress, and the receiver waits for the line to go high.
- Apply a 2 µs low glitch on `rxd` → no strobe and no error; then send A5 A5 5A → `modooperacao` = 8'hA5.
- Assert `reset` while the MODE byte is being received → `modooperacao` = 8'h00, all pulses stay 0, and the next full packet is accepted.

Source files
------------

// File: rtl/uart_modo_pkg.sv
// Shared types and constants for the UART mode-command receiver.
// Build option: define UART_PARITY_EN for 8E1 framing (default 8N1).
package uart_modo_pkg;

  localparam int OVS        = 16;
  localparam int SAMPLE_MID = 8;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_SYNC = 2'd1,
    GOT_MODE = 2'd2
  } pkt_state_e;

  // Oversample divider; clamped to 1 so very slow clocks still produce a tick.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVS);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: 2-flop synchronizer, x16 oversampling divider and byte FSM.
// Build option: UART_PARITY_EN adds an even-parity bit after bit 7.
module uart_rx_core
  import uart_modo_pkg::*;
#(
  parameter int DIV = 325
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

`ifdef UART_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0]       OVS_LAST = 4'(OVS - 1);
  localparam logic [3:0]       MID_LAST = 4'(SAMPLE_MID - 1);
  localparam logic [3:0]       BIT_LAST = 4'(NBITS - 1);

  logic             meta_q, sync_q, prev_q;
  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       ovs_q, ovs_d;
  logic [3:0]       bit_q, bit_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic             wait_high_q, wait_high_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             fall, tick, sample_pt, stop_sample, parity_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall        = prev_q & ~sync_q;
  assign tick        = (state_q != R_IDLE) && (div_q == DIV_LAST);
  assign sample_pt   = tick && (ovs_q == OVS_LAST);
  assign stop_sample = (state_q == R_STOP) && !wait_high_q && sample_pt;
`ifdef UART_PARITY_EN
  assign parity_ok   = ~^shift_q;
`else
  assign parity_ok   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= R_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:  if (fall) state_d = R_START;
      R_START: if (tick && ovs_q == MID_LAST) state_d = sync_q ? R_IDLE : R_DATA;
      R_DATA:  if (sample_pt && bit_q == BIT_LAST) state_d = R_STOP;
      R_STOP: begin
        // A low stop bit parks here until the line recovers.
        if (wait_high_q) begin
          if (sync_q) state_d = R_IDLE;
        end else if (sample_pt && sync_q) begin
          state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    div_d       = '0;
    ovs_d       = ovs_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q;

    if (state_q != R_IDLE && state_d != R_IDLE && div_q != DIV_LAST)
      div_d = div_q + 1'b1;

    if (state_d != state_q)
      ovs_d = '0;
    else if (tick)
      ovs_d = (ovs_q == OVS_LAST) ? '0 : ovs_q + 1'b1;

    if (state_q == R_START)
      bit_d = '0;
    if (state_q == R_DATA && sample_pt) begin
      shift_d = {sync_q, shift_q[NBITS-1:1]};
      bit_d   = bit_q + 1'b1;
    end

    if (stop_sample && !sync_q)
      wait_high_d = 1'b1;
    if (state_d != R_STOP)
      wait_high_d = 1'b0;

    valid_d = stop_sample && sync_q && parity_ok;
    ferr_d  = stop_sample && !(sync_q && parity_ok);
    byte_d  = valid_d ? shift_q[7:0] : byte_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      ovs_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      ovs_q       <= ovs_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_modo_rx.sv
// UART front end for LCD1602 operating mode: validates SYNC+MODE+~MODE packets.
// Build option: UART_PARITY_EN selects 8E1 framing in the byte receiver.
module uart_modo_rx
  import uart_modo_pkg::*;
#(
  parameter int         CLK_HZ       = 50_000_000,
  parameter int         BAUD         = 9600,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter logic [7:0] RESET_MODE   = 8'h00,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] modooperacao,
  output logic       modo_valid,
  output logic       frame_err,
  output logic       pkt_err,
  output logic       busy
);

  localparam int               DIV      = calc_div(CLK_HZ, BAUD);
  localparam int               BIT_CLKS = DIV * OVS;
  localparam int               PRE_W    = $clog2(BIT_CLKS);
  localparam int               TO_W     = $clog2(TIMEOUT_BITS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BIT_CLKS - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_BITS);

  logic [7:0]       rx_byte;
  logic             rx_valid, rx_ferr;
  pkt_state_e       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       cand_q, cand_d;
  logic [7:0]       mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             timeout;

  uart_rx_core #(.DIV(DIV)) u_core (
    .clk          (clk),
    .reset        (reset),
    .rxd_i        (rxd),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

  assign timeout = (state_q != IDLE) && (to_q == TO_LIMIT);

  // Bit-time timeout; a byte strobe restarts it and wins over an expiry.
  always_comb begin
    pre_d = pre_q;
    to_d  = to_q;
    if (state_q == IDLE || rx_valid) begin
      pre_d = '0;
      to_d  = '0;
    end else if (!timeout) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        to_d  = to_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rx_valid && rx_byte == SYNC_BYTE) state_d = GOT_SYNC;
      GOT_SYNC: begin
        if (rx_valid)                state_d = GOT_MODE;
        else if (rx_ferr || timeout) state_d = IDLE;
      end
      GOT_MODE: begin
        if (rx_valid || rx_ferr || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cand_d  = cand_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    if (state_q == GOT_SYNC && rx_valid)
      cand_d = rx_byte;
    if (state_q == GOT_MODE && rx_valid) begin
      if (rx_byte == ~cand_q) begin
        mode_d  = cand_q;
        valid_d = 1'b1;
      end else begin
        perr_d  = 1'b1;
      end
    end
    if (timeout && !rx_valid && !rx_ferr)
      perr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      to_q    <= '0;
      cand_q  <= '0;
      mode_q  <= RESET_MODE;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      to_q    <= to_d;
      cand_q  <= cand_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
    end
  end

  assign modooperacao = mode_q;
  assign modo_valid   = valid_q;
  assign pkt_err      = perr_q;
  assign frame_err    = rx_ferr;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_modo_rx.sv
// Directed and randomized packet bench for uart_modo_rx at a scaled-down bit rate.
module tb_uart_modo_rx;

  localparam int         CLK_HZ   = 3_200_000;
  localparam int         BAUD     = 100_000;
  localparam int         BIT      = 32;
  localparam int         TOB      = 20;
  localparam logic [7:0] SYNC     = 8'hA5;
  localparam logic [7:0] RST_MODE = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] modooperacao;
  logic       modo_valid, frame_err, pkt_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cnt_valid = 0, cnt_perr = 0, cnt_ferr = 0;
  int last_valid_cyc = 0, stop_start_cyc = 0;

  uart_modo_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .SYNC_BYTE(SYNC),
    .RESET_MODE(RST_MODE), .TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .modooperacao(modooperacao),
    .modo_valid(modo_valid), .frame_err(frame_err), .pkt_err(pkt_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (modo_valid) begin
      cnt_valid      <= cnt_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (pkt_err)   cnt_perr <= cnt_perr + 1;
    if (frame_err) cnt_ferr <= cnt_ferr + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Drives one frame; a low stop bit is held for three bit times.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [7:0] d;
    d = b;
    rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(posedge clk);
    end
`ifdef UART_PARITY_EN
    rxd = ^d;
    repeat (BIT) @(posedge clk);
`endif
    stop_start_cyc = cyc;
    rxd = stop_bit;
    repeat (stop_bit ? BIT : 3 * BIT) @(posedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] m, input logic [7:0] c);
    send_byte(s, 1'b1);
    send_byte(m, 1'b1);
    send_byte(c, 1'b1);
  endtask

  initial begin
    logic [7:0] exp_mode, m, c, part;
    int exp_valid, exp_perr, v0, p0, f0, first, lat;

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (4) @(posedge clk);
    reset = 1'b0;
    settle();
    check("reset_mode",  32'(modooperacao), 32'(RST_MODE));
    check("reset_valid", 32'(modo_valid), 32'd0);
    check("reset_ferr",  32'(frame_err), 32'd0);
    check("reset_perr",  32'(pkt_err), 32'd0);
    check("reset_busy",  32'(busy), 32'd0);
    repeat (2 * BIT) @(posedge clk);

    // Good packet and its latency from the CHECK stop bit
    send_pkt(SYNC, 8'h3C, 8'hC3);
    settle();
    exp_mode = 8'h3C;
    check("good_mode",  32'(modooperacao), 32'(exp_mode));
    check("good_valid", 32'(cnt_valid), 32'd1);
    lat = last_valid_cyc - stop_start_cyc;
    check("good_latency_window", 32'(lat >= BIT / 2 - 2 && lat <= BIT / 2 + 12), 32'd1);
    check("good_busy", 32'(busy), 32'd0);

    // Bad check byte
    v0 = cnt_valid; p0 = cnt_perr;
    send_pkt(SYNC, 8'h3C, 8'hC4);
    settle();
    check("badchk_perr",  32'(cnt_perr - p0), 32'd1);
    check("badchk_valid", 32'(cnt_valid - v0), 32'd0);
    check("badchk_mode",  32'(modooperacao), 32'(exp_mode));
    check("badchk_busy",  32'(busy), 32'd0);

    // Inter-byte timeout after SYNC
    p0 = cnt_perr;
    send_byte(SYNC, 1'b1);
    first = -1;
    for (int i = 0; i < 25 * BIT; i++) begin
      settle();
      if (pkt_err && first < 0) first = i;
    end
    check("timeout_perr",   32'(cnt_perr - p0), 32'd1);
    check("timeout_window", 32'(first >= (TOB - 1) * BIT && first <= TOB * BIT), 32'd1);
    check("timeout_busy",   32'(busy), 32'd0);
    send_pkt(SYNC, 8'h12, 8'hED);
    settle();
    exp_mode = 8'h12;
    check("after_timeout_mode", 32'(modooperacao), 32'(exp_mode));

    // Bad stop bit in IDLE, then in GOT_SYNC
    p0 = cnt_perr; f0 = cnt_ferr;
    send_byte(SYNC, 1'b0);
    repeat (BIT) @(posedge clk);
    settle();
    check("badstop_ferr", 32'(cnt_ferr - f0), 32'd1);
    check("badstop_busy", 32'(busy), 32'd0);
    send_byte(SYNC, 1'b1);
    settle();
    check("sync_busy", 32'(busy), 32'd1);
    send_byte(8'h3C, 1'b0);
    repeat (BIT) @(posedge clk);
    settle();
    check("badstop2_ferr", 32'(cnt_ferr - f0), 32'd2);
    check("badstop2_busy", 32'(busy), 32'd0);
    check("badstop_perr",  32'(cnt_perr - p0), 32'd0);
    check("badstop_mode",  32'(modooperacao), 32'(exp_mode));
    send_pkt(SYNC, 8'h77, 8'h88);
    settle();
    exp_mode = 8'h77;
    check("after_badstop_mode", 32'(modooperacao), 32'(exp_mode));

    // Short low glitch, then SYNC used as mode value
    v0 = cnt_valid; p0 = cnt_perr; f0 = cnt_ferr;
    rxd = 1'b0;
    repeat (10) @(posedge clk);
    rxd = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    settle();
    check("glitch_ferr",  32'(cnt_ferr - f0), 32'd0);
    check("glitch_perr",  32'(cnt_perr - p0), 32'd0);
    check("glitch_valid", 32'(cnt_valid - v0), 32'd0);
    check("glitch_busy",  32'(busy), 32'd0);
    send_pkt(SYNC, 8'hA5, 8'h5A);
    settle();
    exp_mode = 8'hA5;
    check("sync_as_mode", 32'(modooperacao), 32'(exp_mode));

    // Reset in the middle of the MODE byte
    v0 = cnt_valid; p0 = cnt_perr; f0 = cnt_ferr;
    send_byte(SYNC, 1'b1);
    part = 8'h66;
    rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = part[i];
      repeat (BIT) @(posedge clk);
    end
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    settle();
    exp_mode = RST_MODE;
    check("midreset_mode", 32'(modooperacao), 32'(exp_mode));
    check("midreset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2 * BIT) @(posedge clk);
    settle();
    check("midreset_pulses", 32'((cnt_valid - v0) + (cnt_perr - p0) + (cnt_ferr - f0)), 32'd0);
    send_pkt(SYNC, 8'h66, 8'h99);
    settle();
    exp_mode = 8'h66;
    check("after_reset_mode", 32'(modooperacao), 32'(exp_mode));

    // Randomized packets, bytes back to back
    exp_valid = cnt_valid;
    exp_perr  = cnt_perr;
    for (int k = 0; k < 20; k++) begin
      m = 8'($urandom);
      c = ($urandom_range(0, 1) == 1) ? ~m : 8'($urandom);
      send_pkt(SYNC, m, c);
      if (c == ~m) begin
        exp_mode = m;
        exp_valid++;
      end else begin
        exp_perr++;
      end
      settle();
      $display("pkt %0d: mode=%02h check=%02h -> modooperacao=%02h", k, m, c, modooperacao);
      check("rand_mode",  32'(modooperacao), 32'(exp_mode));
      check("rand_valid", 32'(cnt_valid), 32'(exp_valid));
      check("rand_perr",  32'(cnt_perr), 32'(exp_perr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
